// File: rtl/phase_controller.sv
// VeriRISC instruction sequencer: per-phase datapath strobes plus run/halt/single-step control
// of the external phase counter.
module phase_controller #(
  parameter int unsigned PHASE_WIDTH  = 3,
  parameter int unsigned OPCODE_WIDTH = 3,
  parameter int unsigned STEP_SUPPORT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PHASE_WIDTH-1:0]  phase,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    zero,
  input  logic                    step_mode,
  input  logic                    step,
  input  logic                    resume,
  output logic                    phase_en,
  output logic                    sel,
  output logic                    rd,
  output logic                    ld_ir,
  output logic                    halt,
  output logic                    inc_pc,
  output logic                    ld_pc,
  output logic                    ld_ac,
  output logic                    wr,
  output logic                    data_e,
  output logic                    halted,
  output logic                    paused,
  output logic                    instr_done
);

  localparam logic [PHASE_WIDTH-1:0] PH_INST_ADDR  = PHASE_WIDTH'(0);
  localparam logic [PHASE_WIDTH-1:0] PH_INST_FETCH = PHASE_WIDTH'(1);
  localparam logic [PHASE_WIDTH-1:0] PH_INST_LOAD  = PHASE_WIDTH'(2);
  localparam logic [PHASE_WIDTH-1:0] PH_IDLE       = PHASE_WIDTH'(3);
  localparam logic [PHASE_WIDTH-1:0] PH_OP_ADDR    = PHASE_WIDTH'(4);
  localparam logic [PHASE_WIDTH-1:0] PH_OP_FETCH   = PHASE_WIDTH'(5);
  localparam logic [PHASE_WIDTH-1:0] PH_ALU_OP     = PHASE_WIDTH'(6);
  localparam logic [PHASE_WIDTH-1:0] PH_STORE      = PHASE_WIDTH'(7);

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_SKZ = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_STO = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(7);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   instr_done_q, instr_done_d;
  logic   aluop;

  assign aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                 (opcode == OP_XOR) || (opcode == OP_LDA);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      instr_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_done_q <= instr_done_d;
    end
  end

  // Next-state: HLT stops at the end of phase 4, single-step stops at the end of phase 7
  always_comb begin
    state_d      = state_q;
    instr_done_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        instr_done_d = (phase == PH_STORE);
        if ((phase == PH_OP_ADDR) && (opcode == OP_HLT)) begin
          state_d = ST_HALTED;
        end else if ((STEP_SUPPORT != 32'd0) && step_mode && (phase == PH_STORE)) begin
          state_d = ST_PAUSED;
        end
      end
      ST_HALTED: begin
        if (resume) state_d = ST_RUN;
      end
      ST_PAUSED: begin
        if (step || !step_mode) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Strobe decode; everything is masked outside RUN so a frozen counter cannot repeat side effects
  always_comb begin
    phase_en = 1'b0;
    sel      = 1'b0;
    rd       = 1'b0;
    ld_ir    = 1'b0;
    halt     = 1'b0;
    inc_pc   = 1'b0;
    ld_pc    = 1'b0;
    ld_ac    = 1'b0;
    wr       = 1'b0;
    data_e   = 1'b0;
    halted   = rst && (state_q == ST_HALTED);
    paused   = rst && (state_q == ST_PAUSED);
    if (rst && (state_q == ST_RUN)) begin
      phase_en = 1'b1;
      case (phase)
        PH_INST_ADDR: sel = 1'b1;
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == OP_HLT);
        end
        PH_OP_FETCH: rd = aluop;
        PH_ALU_OP: begin
          rd     = aluop;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        PH_STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = (opcode == OP_JMP);
          wr     = (opcode == OP_STO);
          data_e = (opcode == OP_STO);
        end
        default: ;
      endcase
    end
  end

  assign instr_done = instr_done_q;

endmodule

// File: tb/tb_phase_controller.sv
// Bench for phase_controller: table vectors for the strobe decode, plus a modelled phase
// counter driving halt, resume, single-step and reset sequences.
module tb_phase_controller;

  logic       clk, rst;
  logic [2:0] phase, ph_vec, ph_cnt, ns_phase, ns_cnt;
  logic [2:0] opcode;
  logic       zero, step_mode, step, resume, use_cnt;
  logic       phase_en, sel, rd, ld_ir, halt, inc_pc, ld_pc, ld_ac, wr, data_e;
  logic       halted, paused, instr_done;
  logic       ns_phase_en, ns_sel, ns_rd, ns_ld_ir, ns_halt, ns_inc_pc, ns_ld_pc;
  logic       ns_ld_ac, ns_wr, ns_data_e, ns_halted, ns_paused, ns_instr_done;
  logic [9:0] act_v;
  int         n_checks, n_fail;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

  phase_controller #(.STEP_SUPPORT(1)) u_dut (
    .clk(clk), .rst(rst), .phase(phase), .opcode(opcode), .zero(zero),
    .step_mode(step_mode), .step(step), .resume(resume),
    .phase_en(phase_en), .sel(sel), .rd(rd), .ld_ir(ld_ir), .halt(halt),
    .inc_pc(inc_pc), .ld_pc(ld_pc), .ld_ac(ld_ac), .wr(wr), .data_e(data_e),
    .halted(halted), .paused(paused), .instr_done(instr_done)
  );

  phase_controller #(.STEP_SUPPORT(0)) u_dut_ns (
    .clk(clk), .rst(rst), .phase(ns_phase), .opcode(opcode), .zero(zero),
    .step_mode(step_mode), .step(step), .resume(resume),
    .phase_en(ns_phase_en), .sel(ns_sel), .rd(ns_rd), .ld_ir(ns_ld_ir), .halt(ns_halt),
    .inc_pc(ns_inc_pc), .ld_pc(ns_ld_pc), .ld_ac(ns_ld_ac), .wr(ns_wr), .data_e(ns_data_e),
    .halted(ns_halted), .paused(ns_paused), .instr_done(ns_instr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Phase counters feeding each instance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph_cnt <= 3'd0;
      ns_cnt <= 3'd0;
    end else begin
      if (phase_en)    ph_cnt <= ph_cnt + 3'd1;
      if (ns_phase_en) ns_cnt <= ns_cnt + 3'd1;
    end
  end

  assign phase    = use_cnt ? ph_cnt : ph_vec;
  assign ns_phase = use_cnt ? ns_cnt : ph_vec;
  assign act_v    = {phase_en, sel, rd, ld_ir, halt, inc_pc, ld_pc, ld_ac, wr, data_e};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {phase_en, sel, rd, ld_ir, halt, inc_pc, ld_pc, ld_ac, wr, data_e} while running
  function automatic logic [9:0] model(input logic [2:0] p, input logic [2:0] op, input logic z);
    logic       alu;
    logic [9:0] v;
    alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    v   = 10'b1_0_0_0_0_0_0_0_0_0;
    case (p)
      3'd0: v[8] = 1'b1;
      3'd1: begin v[8] = 1'b1; v[7] = 1'b1; end
      3'd2, 3'd3: begin v[8] = 1'b1; v[7] = 1'b1; v[6] = 1'b1; end
      3'd4: begin v[5] = (op == HLT); v[4] = 1'b1; end
      3'd5: v[7] = alu;
      3'd6: begin
        v[7] = alu; v[4] = (op == SKZ) && z; v[3] = (op == JMP); v[0] = (op == STO);
      end
      default: begin
        v[7] = alu; v[2] = alu; v[3] = (op == JMP); v[1] = (op == STO); v[0] = (op == STO);
      end
    endcase
    return v;
  endfunction

  // Entered at a falling edge with phase 0 presented; leaves at the falling edge of the next phase 0
  task automatic run_instr(input logic [2:0] op, input logic z, input logic first_done);
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        opcode = op;
        zero   = z;
      end
      #1;
      check("instr_phase", 32'(phase), 32'(i));
      check("instr_strobes", 32'(act_v), 32'(model(3'(i), op, z)));
      check("instr_done", 32'(instr_done), 32'((i == 0) ? first_done : 1'b0));
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [2:0] ph;
    logic [2:0] op;
    logic       z;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[16];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vecs[0]  = '{3'd0, LDA, 1'b0, 10'b1_1_0_0_0_0_0_0_0_0};
    vecs[1]  = '{3'd1, ADD, 1'b0, 10'b1_1_1_0_0_0_0_0_0_0};
    vecs[2]  = '{3'd2, AND, 1'b0, 10'b1_1_1_1_0_0_0_0_0_0};
    vecs[3]  = '{3'd3, XOR, 1'b1, 10'b1_1_1_1_0_0_0_0_0_0};
    vecs[4]  = '{3'd4, ADD, 1'b0, 10'b1_0_0_0_0_1_0_0_0_0};
    vecs[5]  = '{3'd5, LDA, 1'b0, 10'b1_0_1_0_0_0_0_0_0_0};
    vecs[6]  = '{3'd5, STO, 1'b0, 10'b1_0_0_0_0_0_0_0_0_0};
    vecs[7]  = '{3'd6, SKZ, 1'b1, 10'b1_0_0_0_0_1_0_0_0_0};
    vecs[8]  = '{3'd6, SKZ, 1'b0, 10'b1_0_0_0_0_0_0_0_0_0};
    vecs[9]  = '{3'd6, JMP, 1'b0, 10'b1_0_0_0_0_0_1_0_0_0};
    vecs[10] = '{3'd6, STO, 1'b0, 10'b1_0_0_0_0_0_0_0_0_1};
    vecs[11] = '{3'd7, STO, 1'b0, 10'b1_0_0_0_0_0_0_0_1_1};
    vecs[12] = '{3'd7, ADD, 1'b0, 10'b1_0_1_0_0_0_0_1_0_0};
    vecs[13] = '{3'd7, JMP, 1'b1, 10'b1_0_0_0_0_0_1_0_0_0};
    vecs[14] = '{3'd6, LDA, 1'b1, 10'b1_0_1_0_0_0_0_0_0_0};
    vecs[15] = '{3'd4, HLT, 1'b0, 10'b1_0_0_0_1_1_0_0_0_0};

    rst = 1'b1; use_cnt = 1'b0; ph_vec = 3'd0; opcode = LDA; zero = 1'b0;
    step_mode = 1'b0; step = 1'b0; resume = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("reset_strobes", 32'(act_v), 32'd0);
    check("reset_done", 32'(instr_done), 32'd0);
    check("reset_status", 32'({halted, paused}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Strobe decode table; the HLT@4 vector is last and reset lands before its edge
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ph_vec = vecs[i].ph;
      opcode = vecs[i].op;
      zero   = vecs[i].z;
      #1;
      check("table_strobes", 32'(act_v), 32'(vecs[i].exp));
    end
    rst = 1'b0;
    use_cnt = 1'b1;
    @(negedge clk);
    rst = 1'b1;

    // Free-running program
    run_instr(LDA, 1'b0, 1'b0);
    run_instr(ADD, 1'b0, 1'b1);
    run_instr(STO, 1'b0, 1'b1);
    run_instr(JMP, 1'b0, 1'b1);
    run_instr(SKZ, 1'b1, 1'b1);
    run_instr(SKZ, 1'b0, 1'b1);

    // HLT: halt through phase 4, freeze at 5, resume finishes as a no-op
    for (int i = 0; i < 5; i++) begin
      if (i == 0) opcode = HLT;
      #1;
      check("hlt_strobes", 32'(act_v), 32'(model(3'(i), HLT, zero)));
      @(negedge clk);
    end
    for (int k = 0; k < 20; k++) begin
      #1;
      check("halted_flag", 32'(halted), 32'd1);
      check("halted_phase", 32'(phase), 32'd5);
      check("halted_strobes", 32'(act_v), 32'd0);
      @(negedge clk);
    end
    step = 1'b1;
    step_mode = 1'b1;
    #1;
    check("halted_ignores_step", 32'(halted), 32'd1);
    @(negedge clk);
    step = 1'b0;
    step_mode = 1'b0;
    resume = 1'b1;
    #1;
    check("resume_cycle_halted", 32'(halted), 32'd1);
    @(negedge clk);
    resume = 1'b0;
    for (int i = 5; i < 8; i++) begin
      #1;
      check("resume_phase", 32'(phase), 32'(i));
      check("resume_halted", 32'(halted), 32'd0);
      check("resume_strobes", 32'(act_v), 32'(model(3'(i), HLT, zero)));
      @(negedge clk);
    end
    run_instr(LDA, 1'b0, 1'b1);

    // Single step
    step_mode = 1'b1;
    run_instr(LDA, 1'b0, 1'b1);
    #1;
    check("pause_flag", 32'(paused), 32'd1);
    check("pause_phase", 32'(phase), 32'd0);
    check("pause_strobes", 32'(act_v), 32'd0);
    check("pause_done", 32'(instr_done), 32'd1);
    check("nostep_paused", 32'(ns_paused), 32'd0);
    check("nostep_phase_en", 32'(ns_phase_en), 32'd1);
    @(negedge clk);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("pause_hold", 32'({paused, phase, instr_done}), 32'({1'b1, 3'd0, 1'b0}));
      check("pause_hold_strobes", 32'(act_v), 32'd0);
      @(negedge clk);
    end
    step = 1'b1;
    #1;
    check("step_cycle_paused", 32'(paused), 32'd1);
    @(negedge clk);
    step = 1'b0;
    run_instr(ADD, 1'b0, 1'b0);
    #1;
    check("repause_flag", 32'({paused, phase, instr_done}), 32'({1'b1, 3'd0, 1'b1}));
    check("nostep_never_paused", 32'(ns_paused), 32'd0);

    // Reset while paused
    rst = 1'b0;
    #1;
    check("rst_paused_flag", 32'(paused), 32'd0);
    check("rst_paused_strobes", 32'(act_v), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_instr(XOR, 1'b0, 1'b0);
    #1;
    check("pause_again", 32'(paused), 32'd1);
    @(negedge clk);
    step_mode = 1'b0;
    #1;
    check("drop_mode_cycle", 32'(paused), 32'd1);
    @(negedge clk);
    #1;
    check("drop_mode_free", 32'(paused), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_instr(AND, 1'b0, 1'b0);
    run_instr(LDA, 1'b0, 1'b1);

    // Reset while halted
    for (int i = 0; i < 5; i++) begin
      if (i == 0) opcode = HLT;
      @(negedge clk);
    end
    #1;
    check("halt_before_rst", 32'(halted), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_halted_flag", 32'(halted), 32'd0);
    check("rst_halted_strobes", 32'(act_v), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Reset at phase 6 of JMP
    for (int i = 0; i < 6; i++) begin
      if (i == 0) opcode = JMP;
      @(negedge clk);
    end
    #1;
    check("jmp_ph6_ld_pc", 32'({phase, ld_pc}), 32'({3'd6, 1'b1}));
    rst = 1'b0;
    #1;
    check("jmp_rst_strobes", 32'(act_v), 32'd0);
    check("jmp_rst_done", 32'(instr_done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_run", 32'({phase, act_v}), 32'({3'd0, model(3'd0, JMP, zero)}));
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_controller.md
Name: phase_controller

Overview:
Instruction sequencer for the VeriRISC CPU. It consumes the 3-bit phase produced by the phase counter, plus the current opcode and the accumulator zero flag, and decodes the per-phase control strobes for the datapath. The strobes include the load and increment controls for the program counter. It also owns the run/halt/single-step state and drives the phase counter enable, so the CPU can stop on HLT, resume, and execute one instruction at a time.

Parameters:
PHASE_WIDTH, 3, phase bus width; only 3 is supported (8 phases).
OPCODE_WIDTH, 3, opcode bus width; only 3 is supported.
STEP_SUPPORT, 1, 1 enables single-step; 0 ignores step_mode/step, so PAUSED is unreachable.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
phase  input  3  current phase from phase counter: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE
opcode  input  3  IR opcode: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP
zero  input  1  accumulator == 0
step_mode  input  1  level; 1 = pause after each instruction
step  input  1  1-cycle pulse; release one instruction from PAUSED
resume  input  1  1-cycle pulse; leave HALTED
phase_en  output  1  enable to phase counter
sel  output  1  address mux selects PC
rd  output  1  memory read
ld_ir  output  1  load instruction register
halt  output  1  HLT decoded (phase 4)
inc_pc  output  1  PC enable
ld_pc  output  1  PC load
ld_ac  output  1  accumulator load
wr  output  1  memory write
data_e  output  1  data bus drive enable
halted  output  1  state == HALTED
paused  output  1  state == PAUSED
instr_done  output  1  registered 1-cycle pulse after each completed phase-7 cycle

Behaviour:
- FSM states are RUN, HALTED, and PAUSED. A 2-bit register holds the state. instr_done is a flop; all other outputs are combinational from the state and inputs.
- While rst is low, asynchronously: state=RUN, instr_done=0. All outputs are 0, including phase_en, because strobes are gated by rst.
- RUN: phase_en=1. The strobes decode from phase/opcode/zero. ALUOP means opcode in {ADD, AND, XOR, LDA}.
  - phase 0: sel.
  - phase 1: sel, rd.
  - phase 2: sel, rd, ld_ir.
  - phase 3: sel, rd, ld_ir.
  - phase 4: inc_pc=1; halt=(opcode==HLT).
  - phase 5: rd=ALUOP.
  - phase 6: rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP); data_e=(opcode==STO).
  - phase 7: rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode==JMP); wr=(opcode==STO); data_e=(opcode==STO).
- HALTED and PAUSED: phase_en=0 and every strobe is 0. Masking prevents repeated inc_pc/wr while the phase counter is frozen.
- RUN->HALTED occurs at the edge ending phase 4 with opcode==HLT. phase_en stays 1 during that cycle, so the counter advances to 5 and the PC has incremented past the HLT. This guarantees no re-halt on resume.
- HALTED->RUN occurs on resume=1. Execution continues at phase 5 and the HLT instruction finishes its remaining phases as a no-op. step and step_mode are ignored in HALTED.
- RUN->PAUSED occurs at the edge ending phase 7 when STEP_SUPPORT=1 and step_mode=1. The counter wraps to 0 at that edge.
- PAUSED->RUN occurs on step=1 or step_mode=0. With step_mode still 1, exactly one instruction (8 phases) executes before the next pause.
- instr_done is set to 1 at every edge that ends a RUN phase-7 cycle, and is 0 otherwise.
- Simultaneous events:
  - In RUN, resume and step are ignored.
  - HLT halting at phase 4 cannot coincide with the phase-7 pause.
  - resume in PAUSED has no effect.
- Reset mid-instruction returns the state to RUN immediately. Strobes resume from whatever phase is presented after reset deasserts.

Test Plan:
- Reset, then program LDA/ADD/STO/JMP with step_mode=0 -> phase_en=1 continuously. Per-phase strobes match the table, e.g. STO at phase 7 gives wr=1, data_e=1, rd=0. instr_done pulses once every 8 cycles.
- SKZ with zero=1, then SKZ with zero=0 -> inc_pc high at phases 4 and 6 in the first case; only at phase 4 in the second.
- HLT fetched -> halt=1 and inc_pc=1 in phase 4. halted=1 from the next cycle with phase held at 5, all strobes 0, phase_en=0 for 20 idle cycles. A resume pulse gives halted=0 and the phase advances 5,6,7,0.
- step_mode=1 -> paused=1 after phase 7, phase 0 held, no strobes. A step pulse gives exactly 8 phases, then paused=1 again. Dropping step_mode gives free run.
- step_mode=1 with STEP_SUPPORT=0 -> never pauses, same as scenario 1.
- Assert rst low at phase 6 of JMP while HALTED/PAUSED variants are active -> outputs go 0 asynchronously before the next edge, and the state returns to RUN after release.
